uart_flow_status_ctrl: RTL and testbench
========================================

Name: uart_flow_status_ctrl

Overview:
Parametrised successor to the top-level RTS/heartbeat logic, intended for multi-channel UART builds. It provides per-channel RTS generation with watermark hysteresis and per-channel CTS synchronisation with a deglitch filter. It also drives an LED sequencer that shows a heartbeat when healthy and blinks the bridge error code when faulted. It sits beside the UART bridge(s) in the top level and consumes FIFO levels and the bridge error code.

Parameters:
NUM_CH, 1, number of UART channels (>=1)
FIFO_DEPTH, 64, RX FIFO depth per channel; LEVEL_W = $clog2(FIFO_DEPTH+1)
HIGH_WM, 48, RX level at or above which RTS is deasserted
LOW_WM, 16, RX level at or below which RTS is reasserted; must satisfy LOW_WM < HIGH_WM <= FIFO_DEPTH, otherwise $error at elaboration
CTS_DEGLITCH, 4, consecutive stable cycles required before the filtered CTS updates (>=1)
HB_DIV_LOG2, 26, heartbeat counter width; heartbeat LED = counter MSB
BLINK_TICKS, 12_500_000, clock cycles per blink phase (>=1)
GAP_TICKS, 10, blink phases of LED-off between error-code repetitions (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
rx_level  in  NUM_CH*LEVEL_W  RX FIFO occupancy; channel i at [i*LEVEL_W +: LEVEL_W]
rx_full  in  NUM_CH  RX FIFO full per channel
uart_rts_n  out  NUM_CH  RTS per channel, active low
uart_cts_n  in  NUM_CH  raw external CTS, active low, asynchronous
tx_allow  out  NUM_CH  filtered CTS asserted; TX may start
cts_change  out  NUM_CH  one-cycle pulse when tx_allow toggles
error_code  in  8  bridge error code; 0 = no error
led  out  1  status LED
led_mode  out  1  0 = heartbeat, 1 = error blink

Behaviour:
- Reset (async assert, sync release): uart_rts_n = all 1, tx_allow = 0, cts_change = 0, led = 0, led_mode = 0. CTS sync flops reset to 1. Heartbeat counter, prescaler and sequencer all reset to 0 / HEARTBEAT.
- RTS, per channel, registered with 1-cycle latency:
  - OPEN -> BLOCKED when rx_full or level >= HIGH_WM.
  - BLOCKED -> OPEN when !rx_full and level <= LOW_WM.
  - Otherwise the state holds, so levels strictly between the watermarks never toggle RTS.
  - rx_full has priority over level.
  - uart_rts_n = (state == BLOCKED). The first cycle after reset evaluates from BLOCKED.
- CTS, per channel:
  - 2-flop synchroniser, then a deglitch counter.
  - When the synced value differs from the filtered value, the counter increments; it clears whenever synced equals filtered.
  - When the counter reaches CTS_DEGLITCH, filtered <= synced and cts_change pulses for 1 cycle.
  - tx_allow = !filtered.
  - Latency from a clean edge: 2 + CTS_DEGLITCH cycles. Any shorter pulse is rejected.
- Heartbeat counter is free-running HB_DIV_LOG2 bits and wraps silently.
- LED sequencer:
  - Prescaler emits a tick every BLINK_TICKS cycles. It is cleared on every state entry.
  - Latch rule: pulses = error_code[3:0]; the value 0 maps to 16.
  - HEARTBEAT: led = counter MSB, led_mode = 0. If error_code != 0, latch pulses and go to PULSE_ON (same-cycle decision; next-cycle entry).
  - PULSE_ON: led = 1 for 1 tick, then PULSE_OFF.
  - PULSE_OFF: led = 0 for 1 tick; pulses decrements. Go to PULSE_ON if pulses remain, else GAP.
  - GAP: led = 0 for GAP_TICKS ticks. Then, if error_code != 0, re-latch and go to PULSE_ON; else go to HEARTBEAT.
  - led_mode = 1 in PULSE_ON, PULSE_OFF and GAP.
  - error_code changes mid-sequence are ignored until the GAP exit.
  - led and led_mode are registered.
- Reset mid-operation: all outputs go to reset values immediately (asynchronously). No partial sequence resumes.
- Channels are fully independent; no cross-channel logic.

Test Plan:
- Reset: hold rst_n = 0 with rx_level = 0 and CTS low -> uart_rts_n = 1, tx_allow = 0, led = 0, led_mode = 0. One cycle after release, uart_rts_n = 0.
- Hysteresis (HIGH_WM = 48, LOW_WM = 16):
  - Ramp level 0 -> 47 -> rts_n stays 0.
  - Level 48 -> rts_n = 1 next cycle.
  - Fall to 17 -> rts_n stays 1.
  - Level 16 -> rts_n = 0.
  - Level 10 with rx_full = 1 -> rts_n = 1.
- CTS deglitch (CTS_DEGLITCH = 4):
  - Drive cts_n low for 3 cycles -> tx_allow stays 0, no cts_change.
  - Drive low for 10 cycles -> tx_allow = 1 exactly 6 cycles after the edge, with a single cts_change pulse.
- Error blink (BLINK_TICKS = 4, GAP_TICKS = 3):
  - error_code = 8'h03 -> 3 pulses (4 cycles high / 4 cycles low each), then 12 cycles low, then the sequence repeats. led_mode = 1 throughout.
  - Clear error_code during the 2nd pulse -> the sequence completes, then led_mode = 0 after the GAP.
  - error_code = 8'h10 -> 16 pulses per repetition.
- Async reset during PULSE_ON -> led = 0 and led_mode = 0 without a clock edge. After release, the block starts in HEARTBEAT and re-enters PULSE_ON if the error persists.
- NUM_CH = 2: ch0 level 50 and ch1 level 5 -> uart_rts_n = 2'b01. Toggle only ch1 CTS -> only tx_allow[1] and cts_change[1] respond.

Source files
------------

// File: rtl/uart_flow_status_ctrl.sv
// uart_flow_status_ctrl: per-channel RTS hysteresis, CTS synchronise/deglitch,
// and a status LED that shows a heartbeat or blinks the bridge error code.
module uart_flow_status_ctrl #(
   parameter int NUM_CH       = 1,
   parameter int FIFO_DEPTH   = 64,
   parameter int HIGH_WM      = 48,
   parameter int LOW_WM       = 16,
   parameter int CTS_DEGLITCH = 4,
   parameter int HB_DIV_LOG2  = 26,
   parameter int BLINK_TICKS  = 12_500_000,
   parameter int GAP_TICKS    = 10,
   localparam int LEVEL_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CH*LEVEL_W-1:0]   rx_level,
   input  logic [NUM_CH-1:0]           rx_full,
   output logic [NUM_CH-1:0]           uart_rts_n,
   input  logic [NUM_CH-1:0]           uart_cts_n,
   output logic [NUM_CH-1:0]           tx_allow,
   output logic [NUM_CH-1:0]           cts_change,
   input  logic [7:0]                  error_code,
   output logic                        led,
   output logic                        led_mode
);

   localparam int DG_W  = $clog2(CTS_DEGLITCH + 1);
   localparam int PRE_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

   localparam logic [LEVEL_W-1:0] HIGH_LVL = LEVEL_W'(HIGH_WM);
   localparam logic [LEVEL_W-1:0] LOW_LVL  = LEVEL_W'(LOW_WM);
   localparam logic [DG_W-1:0]    DG_LAST  = DG_W'(CTS_DEGLITCH - 1);
   localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(BLINK_TICKS - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(GAP_TICKS - 1);

   // Reject parameter sets that would make the watermarks meaningless.
   if (!(LOW_WM < HIGH_WM && HIGH_WM <= FIFO_DEPTH)) begin : g_bad_wm
      $error("uart_flow_status_ctrl: need LOW_WM < HIGH_WM <= FIFO_DEPTH");
   end
   if (NUM_CH < 1 || CTS_DEGLITCH < 1 || BLINK_TICKS < 1 || GAP_TICKS < 1 || HB_DIV_LOG2 < 1) begin : g_bad_cfg
      $error("uart_flow_status_ctrl: NUM_CH, CTS_DEGLITCH, BLINK_TICKS, GAP_TICKS, HB_DIV_LOG2 must be >= 1");
   end

   // ------------------------------------------------------------------
   // RTS: blocked on full or high watermark, released only at low watermark
   // ------------------------------------------------------------------
   logic [NUM_CH-1:0] blocked_d, blocked_q;

   // Next blocked state per channel; levels between the watermarks hold.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      blocked_d = blocked_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rx_full[i] || (rx_level[i*LEVEL_W +: LEVEL_W] >= HIGH_LVL)) begin
            blocked_d[i] = 1'b1;
         end else if (rx_level[i*LEVEL_W +: LEVEL_W] <= LOW_LVL) begin
            blocked_d[i] = 1'b0;
         end
      end
   end

   // Blocked state register; comes out of reset blocked (RTS deasserted).
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignment so all flops sample together.
      if (!rst_n) blocked_q <= '1;
      else        blocked_q <= blocked_d;
   end

   assign uart_rts_n = blocked_q;

   // ------------------------------------------------------------------
   // CTS: two-flop synchroniser followed by a consecutive-cycle deglitch
   // ------------------------------------------------------------------
   logic [NUM_CH-1:0]            sync1_d, sync1_q, sync2_d, sync2_q;
   logic [NUM_CH-1:0]            filt_d, filt_q, change_d, change_q;
   logic [NUM_CH-1:0][DG_W-1:0]  dg_cnt_d, dg_cnt_q;

   // Filter only commits after CTS_DEGLITCH consecutive differing samples.
   always_comb begin
      sync1_d  = uart_cts_n;
      sync2_d  = sync1_q;
      filt_d   = filt_q;
      change_d = '0;
      dg_cnt_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sync2_q[i] != filt_q[i]) begin
            if (dg_cnt_q[i] == DG_LAST) begin
               filt_d[i]   = sync2_q[i];
               change_d[i] = 1'b1;
            end else begin
               dg_cnt_d[i] = dg_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // CTS pipeline registers; idle (deasserted, high) out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '1;
         sync2_q  <= '1;
         filt_q   <= '1;
         change_q <= '0;
         dg_cnt_q <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         filt_q   <= filt_d;
         change_q <= change_d;
         dg_cnt_q <= dg_cnt_d;
      end
   end

   assign tx_allow   = ~filt_q;
   assign cts_change = change_q;

   // ------------------------------------------------------------------
   // LED: heartbeat when healthy, blinked error code when faulted
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_HEARTBEAT = 2'd0,
      ST_PULSE_ON  = 2'd1,
      ST_PULSE_OFF = 2'd2,
      ST_GAP       = 2'd3
   } led_state_e;

   led_state_e              state_d, state_q;
   logic [PRE_W-1:0]        presc_d, presc_q;
   logic [GAP_W-1:0]        gap_d, gap_q;
   logic [4:0]              pulses_d, pulses_q;
   logic [HB_DIV_LOG2-1:0]  hb_d, hb_q;
   logic                    led_d, led_q, led_mode_d, led_mode_q;
   logic                    tick;
   logic [4:0]              latch_pulses;

   assign tick         = (presc_q == PRE_LAST);
   // A low nibble of zero means sixteen pulses.
   assign latch_pulses = (error_code[3:0] == 4'd0) ? 5'd16 : {1'b0, error_code[3:0]};

   // Sequencer next state, prescaler/gap counting and registered LED outputs.
   always_comb begin
      state_d  = state_q;
      pulses_d = pulses_q;
      gap_d    = gap_q;
      hb_d     = hb_q + 1'b1;

      case (state_q)
         ST_HEARTBEAT: begin
            if (error_code != 8'd0) begin
               pulses_d = latch_pulses;
               state_d  = ST_PULSE_ON;
            end
         end
         ST_PULSE_ON: begin
            if (tick) state_d = ST_PULSE_OFF;
         end
         ST_PULSE_OFF: begin
            if (tick) begin
               pulses_d = pulses_q - 1'b1;
               state_d  = (pulses_q == 5'd1) ? ST_GAP : ST_PULSE_ON;
            end
         end
         ST_GAP: begin
            if (tick) begin
               if (gap_q == GAP_LAST) begin
                  if (error_code != 8'd0) begin
                     pulses_d = latch_pulses;
                     state_d  = ST_PULSE_ON;
                  end else begin
                     state_d  = ST_HEARTBEAT;
                  end
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
         end
         default: state_d = ST_HEARTBEAT;
      endcase

      // Every state entry restarts the phase timing from zero.
      if (state_d != state_q) begin
         presc_d = '0;
         gap_d   = '0;
      end else if (tick) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + 1'b1;
      end

      // Outputs follow the state being entered so they align with state_q.
      case (state_d)
         ST_HEARTBEAT: led_d = hb_d[HB_DIV_LOG2-1];
         ST_PULSE_ON:  led_d = 1'b1;
         default:      led_d = 1'b0;
      endcase
      led_mode_d = (state_d != ST_HEARTBEAT);
   end

   // Sequencer, heartbeat counter and LED output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_HEARTBEAT;
         presc_q    <= '0;
         gap_q      <= '0;
         pulses_q   <= '0;
         hb_q       <= '0;
         led_q      <= 1'b0;
         led_mode_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         gap_q      <= gap_d;
         pulses_q   <= pulses_d;
         hb_q       <= hb_d;
         led_q      <= led_d;
         led_mode_q <= led_mode_d;
      end
   end

   assign led      = led_q;
   assign led_mode = led_mode_q;

endmodule

// File: tb/tb_uart_flow_status_ctrl.sv
// Self-checking bench for uart_flow_status_ctrl: directed stimulus, a
// behavioural model compared every cycle, plus hand-computed spot checks.
module tb_uart_flow_status_ctrl;

   localparam int NCH = 2;
   localparam int FD  = 64;
   localparam int HWM = 48;
   localparam int LWM = 16;
   localparam int DG  = 4;
   localparam int HBW = 4;
   localparam int BT  = 4;
   localparam int GT  = 3;
   localparam int LW  = $clog2(FD + 1);
   localparam int HL  = DG + 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NCH*LW-1:0]    rx_level;
   logic [NCH-1:0]       rx_full;
   logic [NCH-1:0]       uart_rts_n;
   logic [NCH-1:0]       uart_cts_n;
   logic [NCH-1:0]       tx_allow;
   logic [NCH-1:0]       cts_change;
   logic [7:0]           error_code;
   logic                 led;
   logic                 led_mode;

   always #5 clk = ~clk;

   uart_flow_status_ctrl #(
      .NUM_CH       (NCH),
      .FIFO_DEPTH   (FD),
      .HIGH_WM      (HWM),
      .LOW_WM       (LWM),
      .CTS_DEGLITCH (DG),
      .HB_DIV_LOG2  (HBW),
      .BLINK_TICKS  (BT),
      .GAP_TICKS    (GT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_level   (rx_level),
      .rx_full    (rx_full),
      .uart_rts_n (uart_rts_n),
      .uart_cts_n (uart_cts_n),
      .tx_allow   (tx_allow),
      .cts_change (cts_change),
      .error_code (error_code),
      .led        (led),
      .led_mode   (led_mode)
   );

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [NCH-1:0] m_blocked, m_filt, m_chg, exp_tx;
   logic [HL-1:0]  m_hist [NCH];
   int             m_hb, m_t, m_n;
   bit             m_active;
   logic           exp_led, exp_mode;

   function automatic int latch_n(input logic [7:0] e);
      return (e[3:0] == 4'd0) ? 16 : int'(e[3:0]);
   endfunction

   // LED level t cycles into a sequence of n pulses: n on/off pairs then a gap.
   function automatic logic seq_led(input int t, input int n);
      return (t < n * 2 * BT) && ((t % (2 * BT)) < BT);
   endfunction

   assign exp_tx = ~m_filt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_blocked <= '1;
         m_filt    <= '1;
         m_chg     <= '0;
         for (int c = 0; c < NCH; c++) m_hist[c] <= '1;
         m_hb      <= 0;
         m_active  <= 1'b0;
         m_t       <= 0;
         m_n       <= 0;
         exp_led   <= 1'b0;
         exp_mode  <= 1'b0;
      end else begin
         logic [NCH-1:0] nb, nf, nc;
         logic [HL-1:0]  nh;
         bit             diff, act;
         int             lvl, t, n, hb;
         nb = m_blocked;
         nf = m_filt;
         nc = '0;
         for (int c = 0; c < NCH; c++) begin
            lvl = int'(rx_level[c*LW +: LW]);
            if (rx_full[c] || lvl >= HWM) nb[c] = 1'b1;
            else if (lvl <= LWM)          nb[c] = 1'b0;
            // nh[j] is the raw CTS sample taken j edges ago; the filter
            // flips when samples 2..DG+1 edges old all disagree with it.
            nh   = {m_hist[c][HL-2:0], uart_cts_n[c]};
            diff = 1'b1;
            for (int j = 2; j <= DG + 1; j++) if (nh[j] == m_filt[c]) diff = 1'b0;
            if (diff) begin
               nf[c] = ~m_filt[c];
               nc[c] = 1'b1;
            end
            m_hist[c] <= nh;
         end
         hb  = m_hb + 1;
         act = m_active;
         t   = m_t;
         n   = m_n;
         if (!act) begin
            if (error_code != 8'd0) begin
               act = 1'b1;
               t   = 0;
               n   = latch_n(error_code);
            end
         end else if (t == n * 2 * BT + GT * BT - 1) begin
            if (error_code != 8'd0) begin
               t = 0;
               n = latch_n(error_code);
            end else begin
               act = 1'b0;
            end
         end else begin
            t++;
         end
         m_blocked <= nb;
         m_filt    <= nf;
         m_chg     <= nc;
         m_hb      <= hb;
         m_active  <= act;
         m_t       <= t;
         m_n       <= n;
         exp_led   <= act ? seq_led(t, n) : hb[HBW-1];
         exp_mode  <= act;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_rts_n",      uart_rts_n, m_blocked);
         check("cyc_tx_allow",   tx_allow,   exp_tx);
         check("cyc_cts_change", cts_change, m_chg);
         check("cyc_led",        led,        exp_led);
         check("cyc_led_mode",   led_mode,   exp_mode);
      end
   end

   // ---------------- stimulus helpers ----------------
   logic led_rec  [256];
   logic mode_rec [256];
   int   s_rises, s_high, s_modes;

   task automatic set_level(input int ch, input int val);
      rx_level[ch*LW +: LW] = LW'(val);
   endtask

   task automatic capture(input int len, input int clr_at);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         led_rec[i]  = led;
         mode_rec[i] = led_mode;
         if (i == clr_at) error_code = 8'd0;
      end
   endtask

   task automatic summarize(input int len);
      logic prev;
      prev    = 1'b0;
      s_rises = 0;
      s_high  = 0;
      s_modes = 0;
      for (int i = 0; i < len; i++) begin
         if (led_rec[i] && !prev) s_rises++;
         s_high  += int'(led_rec[i]);
         s_modes += int'(mode_rec[i]);
         prev     = led_rec[i];
      end
   endtask

   task automatic wait_heartbeat(input string name);
      for (int i = 0; i < 200 && led_mode; i++) @(negedge clk);
      check(name, led_mode, 1'b0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int hi, c0, c1, chg;
      rst_n      = 1'b0;
      rx_level   = '0;
      rx_full    = '0;
      uart_cts_n = '0;
      error_code = 8'd0;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;

      // Reset values with CTS held low.
      check("rst_rts_n",      uart_rts_n, 2'b11);
      check("rst_tx_allow",   tx_allow,   2'b00);
      check("rst_cts_change", cts_change, 2'b00);
      check("rst_led",        led,        1'b0);
      check("rst_led_mode",   led_mode,   1'b0);
      uart_cts_n = '1;
      rst_n      = 1'b1;
      @(negedge clk);
      check("rts_open_after_rst", uart_rts_n, 2'b00);

      // Hysteresis on channel 0.
      for (int l = 0; l <= 47; l++) begin
         set_level(0, l);
         @(negedge clk);
         check("ramp_open", uart_rts_n[0], 1'b0);
      end
      set_level(0, 48); @(negedge clk);
      check("hwm_block", uart_rts_n[0], 1'b1);
      set_level(0, 17); repeat (3) @(negedge clk);
      check("between_hold", uart_rts_n[0], 1'b1);
      set_level(0, 16); @(negedge clk);
      check("lwm_open", uart_rts_n[0], 1'b0);
      set_level(0, 10); rx_full[0] = 1'b1; @(negedge clk);
      check("full_block", uart_rts_n[0], 1'b1);
      rx_full[0] = 1'b0; @(negedge clk);
      check("full_release", uart_rts_n[0], 1'b0);

      // CTS: 3-cycle glitch must be rejected.
      uart_cts_n[0] = 1'b0;
      repeat (3) @(negedge clk);
      uart_cts_n[0] = 1'b1;
      chg = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("glitch_tx_allow", tx_allow[0], 1'b0);
         chg += int'(cts_change[0]);
      end
      check("glitch_no_change", chg, 0);

      // CTS: clean low edge appears exactly 6 cycles later with one pulse.
      uart_cts_n[0] = 1'b0;
      chg = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k < 6) check("cts_before_6", tx_allow[0], 1'b0);
         if (k == 6) begin
            check("cts_at_6",    tx_allow[0],   1'b1);
            check("cts_pulse_6", cts_change[0], 1'b1);
         end
         chg += int'(cts_change[0]);
      end
      check("cts_single_pulse", chg, 1);
      uart_cts_n[0] = 1'b1;
      repeat (8) @(negedge clk);
      check("cts_release", tx_allow[0], 1'b0);

      // Two independent channels.
      set_level(0, 50); set_level(1, 5); @(negedge clk);
      check("two_ch_rts", uart_rts_n, 2'b01);
      uart_cts_n[1] = 1'b0;
      c0 = 0; c1 = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         c0 += int'(cts_change[0]);
         c1 += int'(cts_change[1]);
         check("ch0_idle", tx_allow[0], 1'b0);
      end
      check("ch1_allow",  tx_allow[1], 1'b1);
      check("ch1_pulses", c1, 1);
      check("ch0_pulses", c0, 0);
      uart_cts_n[1] = 1'b1;
      set_level(0, 0); set_level(1, 0);
      repeat (8) @(negedge clk);

      // Heartbeat: counter MSB of a 4-bit counter is high 8 of every 16 cycles.
      hi = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         hi += int'(led);
      end
      check("hb_duty", hi, 8);
      check("hb_mode", led_mode, 1'b0);

      // Error code 3: 3 pulses of 4 on / 4 off, 12-cycle gap, then repeat.
      error_code = 8'h03;
      capture(37, -1);
      summarize(36);
      check("e3_rises",   s_rises, 3);
      check("e3_high",    s_high, 12);
      check("e3_mode",    s_modes, 36);
      check("e3_first",   led_rec[0], 1'b1);
      check("e3_off",     led_rec[4], 1'b0);
      check("e3_pulse3",  led_rec[16], 1'b1);
      check("e3_gap_beg", led_rec[24], 1'b0);
      check("e3_gap_end", led_rec[35], 1'b0);
      check("e3_repeat",  led_rec[36], 1'b1);
      error_code = 8'd0;
      wait_heartbeat("e3_return_hb");

      // Clearing the error during the 2nd pulse still completes the sequence.
      error_code = 8'h03;
      capture(37, 9);
      summarize(36);
      check("clr_rises",     s_rises, 3);
      check("clr_mode_gap",  mode_rec[35], 1'b1);
      check("clr_mode_exit", mode_rec[36], 1'b0);

      // Error code 0x10: low nibble zero means 16 pulses.
      error_code = 8'h10;
      capture(141, -1);
      summarize(140);
      check("e16_rises",  s_rises, 16);
      check("e16_high",   s_high, 64);
      check("e16_mode",   s_modes, 140);
      check("e16_repeat", led_rec[140], 1'b1);
      error_code = 8'd0;
      wait_heartbeat("e16_return_hb");

      // Asynchronous reset during PULSE_ON.
      error_code = 8'h05;
      @(negedge clk); @(negedge clk);
      check("pre_rst_led", led, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_led",      led,        1'b0);
      check("async_led_mode", led_mode,   1'b0);
      check("async_rts_n",    uart_rts_n, 2'b11);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("restart_mode", led_mode, 1'b1);
      check("restart_led",  led,      1'b1);
      error_code = 8'd0;
      wait_heartbeat("final_return_hb");
      repeat (5) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
